dense_frame_streamer: RTL

Transmit-side companion to the dense-layer multiply-accumulator. It buffers one flattened feature frame written by the upstream layer. On command, it streams the frame to one or more dense MAC instances using the MAC's input protocol: frame_start, ena, 16-bit signed data and frame_end. It owns the frame-start, element-enable and frame-end timing, so every MAC downstream sees the same element order as its weight ROM address counter.

---
 rtl/dense_frame_streamer_if.sv | 27 ++
 rtl/dense_frame_streamer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dense_frame_streamer_if.sv
// Handshake bundle between the frame writer/controller and dense_frame_streamer.
// The master side writes the frame and commands streaming; the slave side is the streamer.
interface dense_frame_streamer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  start;
  logic                  hold;
  logic                  busy;
  logic                  done;
  logic                  frame_start_out;
  logic                  ena_out;
  logic [DATA_WIDTH-1:0] dense_output;
  logic                  frame_end_out;

  modport master (
    output wr_en, wr_data, start, hold,
    input  wr_ready, busy, done, frame_start_out, ena_out, dense_output, frame_end_out
  );

  modport slave (
    input  wr_en, wr_data, start, hold,
    output wr_ready, busy, done, frame_start_out, ena_out, dense_output, frame_end_out
  );
endinterface

// File: rtl/dense_frame_streamer.sv
// Buffers one flattened frame and streams it to dense MACs as frame_start/ena/data/frame_end.
// Define DENSE_STREAM_REPLAY_EN to keep the buffer after each frame so start re-streams it.
module dense_frame_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int FRAME_LEN  = 784
) (
  input logic                   clk,
  input logic                   rst_n,
  dense_frame_streamer_if.slave bus
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_READY,
    S_SOF,
    S_STREAM
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_WR   = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH:0]   FRAME_CNT = (ADDR_WIDTH + 1)'(FRAME_LEN);
  localparam logic [ADDR_WIDTH:0]   LAST_RD   = (ADDR_WIDTH + 1)'(FRAME_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_idx, rd_idx_d;
  logic                  mem_we, rd_en;
  logic                  wr_ready_q, wr_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fso_q, fso_d;
  logic                  ena_q, ena_d;
  logic                  fe_q, fe_d;
  logic [DATA_WIDTH-1:0] data_q;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d  = state;
    wr_ptr_d = wr_ptr;
    rd_idx_d = rd_idx;
    mem_we   = 1'b0;
    rd_en    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    fso_d    = 1'b0;
    ena_d    = 1'b0;
    fe_d     = 1'b0;

    case (state)
      S_LOAD: begin
        if (bus.wr_en) begin
          mem_we = 1'b1;
          if (wr_ptr == LAST_WR) begin
            wr_ptr_d = '0;
            state_d  = S_READY;
          end else begin
            wr_ptr_d = wr_ptr + 1'b1;
          end
        end
      end
      S_READY: begin
        if (bus.start) begin
          state_d  = S_SOF;
          fso_d    = 1'b1;
          busy_d   = 1'b1;
          rd_idx_d = '0;
        end
      end
      S_SOF, S_STREAM: begin
        // hold sampled this cycle gates the element presented next cycle, even from SOF
        if (rd_idx != FRAME_CNT) begin
          state_d = S_STREAM;
          busy_d  = 1'b1;
          if (!bus.hold) begin
            rd_en    = 1'b1;
            ena_d    = 1'b1;
            fe_d     = (rd_idx == LAST_RD);
            rd_idx_d = rd_idx + 1'b1;
          end
        end else begin
          done_d = 1'b1;
`ifdef DENSE_STREAM_REPLAY_EN
          state_d = S_READY;
`else
          state_d  = S_LOAD;
          wr_ptr_d = '0;
`endif
        end
      end
      default: state_d = S_LOAD;
    endcase

    wr_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      wr_ptr     <= '0;
      rd_idx     <= '0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fso_q      <= 1'b0;
      ena_q      <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state      <= state_d;
      wr_ptr     <= wr_ptr_d;
      rd_idx     <= rd_idx_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fso_q      <= fso_d;
      ena_q      <= ena_d;
      fe_q       <= fe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // The synchronous RAM read lands directly in the output register, so it holds during stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (rd_en) begin
      data_q <= mem[rd_idx[ADDR_WIDTH-1:0]];
    end
  end

  assign bus.wr_ready        = wr_ready_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.frame_start_out = fso_q;
  assign bus.ena_out         = ena_q;
  assign bus.dense_output    = data_q;
  assign bus.frame_end_out   = fe_q;

endmodule
